// File: rtl/ccsds_turbo_dec_input_buffer_if.sv
// Bus between the decoder source stage, the two-bank input buffer and the SISO engine.
// The slave modport is the buffer's view. The master modport is the source/engine side.
interface ccsds_turbo_dec_input_buffer_if #(
  parameter int pLLR_W  = 5,
  parameter int pADDR_W = 8,
  parameter int pTAG_W  = 4
);
  logic                    iwrite;
  logic                    iwfull;
  logic [pADDR_W-1:0]      iwaddr;
  logic [pTAG_W-1:0]       itag;
  logic [pLLR_W-1:0]       isLLR;
  logic [2:0][pLLR_W-1:0]  ia0LLR;
  logic [2:0][pLLR_W-1:0]  ia1LLR;

  logic                    ofulla;
  logic                    oemptya;
  logic                    ordy;
  logic [pADDR_W-1:0]      olen;
  logic [pTAG_W-1:0]       otag;

  logic                    irempty;
  logic [pADDR_W-1:0]      iraddr;
  logic [pLLR_W-1:0]       osLLR;
  logic [2:0][pLLR_W-1:0]  oa0LLR;
  logic [2:0][pLLR_W-1:0]  oa1LLR;
  logic                    oerr;

  modport slave (
    input  iwrite, iwfull, iwaddr, itag, isLLR, ia0LLR, ia1LLR, irempty, iraddr,
    output ofulla, oemptya, ordy, olen, otag, osLLR, oa0LLR, oa1LLR, oerr
  );

  modport master (
    output iwrite, iwfull, iwaddr, itag, isLLR, ia0LLR, ia1LLR, irempty, iraddr,
    input  ofulla, oemptya, ordy, olen, otag, osLLR, oa0LLR, oa1LLR, oerr
  );
endinterface

// File: rtl/ccsds_turbo_dec_input_buffer.sv
// Two-bank ping-pong store for S/A0/A1 duobit LLR words that sits between the source stage and the SISO engine.
// It tracks bank occupancy for back-pressure and provides a 2-cycle random-access read of the current full bank.
module ccsds_turbo_dec_input_buffer #(
  parameter int pLLR_W  = 5,
  parameter int pADDR_W = 8,
  parameter int pTAG_W  = 4
) (
  input  logic iclk,
  input  logic ireset_n,
  input  logic iclkena,
  ccsds_turbo_dec_input_buffer_if.slave bus
);
  localparam int WORD_W = 6 * pLLR_W;
  localparam int DEPTH  = 2 ** (pADDR_W + 1);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] ram_rd_q;
  logic [WORD_W-1:0] wdata;

  logic                   wbank_q, wbank_d;
  logic                   rbank_q, rbank_d;
  logic [1:0]             used_q, used_d;
  logic [pADDR_W-1:0]     last_waddr_q, last_waddr_d;
  logic [pADDR_W-1:0]     len_q [2];
  logic [pADDR_W-1:0]     len_d [2];
  logic [pTAG_W-1:0]      tag_q [2];
  logic [pTAG_W-1:0]      tag_d [2];
  logic                   ofulla_q, ofulla_d;
  logic                   oemptya_q, oemptya_d;
  logic                   ordy_q, ordy_d;
  logic [pADDR_W-1:0]     olen_q, olen_d;
  logic [pTAG_W-1:0]      otag_q, otag_d;
  logic                   oerr_q, oerr_d;
  logic [pLLR_W-1:0]      os_q, os_d;
  logic [2:0][pLLR_W-1:0] oa0_q, oa0_d;
  logic [2:0][pLLR_W-1:0] oa1_q, oa1_d;

  logic wr_accept, release_ok, close_ok, err_now;

  assign wdata = {bus.isLLR, bus.ia0LLR[2], bus.ia0LLR[1], bus.ia0LLR[0],
                  bus.ia1LLR[2], bus.ia1LLR[0]};

  // The write side always sees the pre-release full flag, so data written in a release cycle is dropped.
  // A close in that same cycle is still accepted once the release frees a bank.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    wr_accept    = bus.iwrite & ~ofulla_q;
    release_ok   = bus.irempty & ordy_q;
    close_ok     = bus.iwfull & (~ofulla_q | release_ok);
    err_now      = (bus.iwrite & ofulla_q) | (bus.iwfull & ofulla_q & ~release_ok) |
                   (bus.irempty & ~ordy_q);

    wbank_d      = wbank_q;
    rbank_d      = rbank_q;
    used_d       = used_q;
    last_waddr_d = last_waddr_q;
    len_d        = len_q;
    tag_d        = tag_q;

    if (wr_accept) last_waddr_d = bus.iwaddr;
    if (close_ok) begin
      len_d[wbank_q] = bus.iwrite ? bus.iwaddr : last_waddr_q;
      tag_d[wbank_q] = bus.itag;
      wbank_d        = ~wbank_q;
    end
    if (release_ok) rbank_d = ~rbank_q;

    unique case ({close_ok, release_ok})
      2'b10:   used_d = used_q + 2'd1;
      2'b01:   used_d = used_q - 2'd1;
      default: used_d = used_q;
    endcase

    ofulla_d  = (used_d == 2'd2);
    oemptya_d = (used_d == 2'd0);
    ordy_d    = (used_d != 2'd0);
    olen_d    = len_q[rbank_q];
    otag_d    = tag_q[rbank_q];
    oerr_d    = oerr_q | err_now;

    os_d      = ram_rd_q[6*pLLR_W-1:5*pLLR_W];
    oa0_d[2]  = ram_rd_q[5*pLLR_W-1:4*pLLR_W];
    oa0_d[1]  = ram_rd_q[4*pLLR_W-1:3*pLLR_W];
    oa0_d[0]  = ram_rd_q[3*pLLR_W-1:2*pLLR_W];
    oa1_d[2]  = ram_rd_q[2*pLLR_W-1:pLLR_W];
    oa1_d[1]  = '0;
    oa1_d[0]  = ram_rd_q[pLLR_W-1:0];
  end

  // NOTE: the RAM and its read register have no reset, so they map onto block RAM.
  always_ff @(posedge iclk) begin
    if (iclkena) begin
      if (wr_accept) mem[{wbank_q, bus.iwaddr}] <= wdata;
      ram_rd_q <= mem[{rbank_q, bus.iraddr}];
    end
  end

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      wbank_q      <= 1'b0;
      rbank_q      <= 1'b0;
      used_q       <= 2'd0;
      last_waddr_q <= '0;
      len_q        <= '{default: '0};
      tag_q        <= '{default: '0};
      ofulla_q     <= 1'b0;
      oemptya_q    <= 1'b1;
      ordy_q       <= 1'b0;
      olen_q       <= '0;
      otag_q       <= '0;
      oerr_q       <= 1'b0;
      os_q         <= '0;
      oa0_q        <= '0;
      oa1_q        <= '0;
    end else if (iclkena) begin
      wbank_q      <= wbank_d;
      rbank_q      <= rbank_d;
      used_q       <= used_d;
      last_waddr_q <= last_waddr_d;
      len_q        <= len_d;
      tag_q        <= tag_d;
      ofulla_q     <= ofulla_d;
      oemptya_q    <= oemptya_d;
      ordy_q       <= ordy_d;
      olen_q       <= olen_d;
      otag_q       <= otag_d;
      oerr_q       <= oerr_d;
      os_q         <= os_d;
      oa0_q        <= oa0_d;
      oa1_q        <= oa1_d;
    end
  end

  assign bus.ofulla  = ofulla_q;
  assign bus.oemptya = oemptya_q;
  assign bus.ordy    = ordy_q;
  assign bus.olen    = olen_q;
  assign bus.otag    = otag_q;
  assign bus.oerr    = oerr_q;
  assign bus.osLLR   = os_q;
  assign bus.oa0LLR  = oa0_q;
  assign bus.oa1LLR  = oa1_q;
endmodule

// File: tb/tb_ccsds_turbo_dec_input_buffer.sv
// Directed bench for the two-bank turbo decoder input buffer: occupancy flags, block close/release,
// 2-cycle read data, overflow/underflow errors, clock enable and asynchronous reset.
module tb_ccsds_turbo_dec_input_buffer;
  localparam int W = 5;
  localparam int A = 8;
  localparam int T = 4;

  logic iclk = 1'b0;
  logic ireset_n = 1'b0;
  logic iclkena = 1'b1;
  int   checks = 0;
  int   errors = 0;

  ccsds_turbo_dec_input_buffer_if #(.pLLR_W(W), .pADDR_W(A), .pTAG_W(T)) bus ();

  ccsds_turbo_dec_input_buffer #(.pLLR_W(W), .pADDR_W(A), .pTAG_W(T)) dut (
    .iclk     (iclk),
    .ireset_n (ireset_n),
    .iclkena  (iclkena),
    .bus      (bus)
  );

  always #5 iclk = ~iclk;

  // Field j of the word with key k. Slots: 0 = s, 1..3 = a0[0..2], 4..6 = a1[0..2].
  function automatic logic [W-1:0] fld(input int k, input int j);
    return W'(k * 5 + j * 7 + 3);
  endfunction

  // Expected read-back as {osLLR, oa0LLR[2:0], oa1LLR[2:0]}. a1[1] always reads as zero.
  function automatic logic [7*W-1:0] exp_word(input int k);
    return {fld(k, 0), fld(k, 3), fld(k, 2), fld(k, 1), fld(k, 6), W'(0), fld(k, 4)};
  endfunction

  task automatic cyc();
    @(posedge iclk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.iwrite  = 1'b0;
    bus.iwfull  = 1'b0;
    bus.iwaddr  = '0;
    bus.itag    = '0;
    bus.isLLR   = '0;
    bus.ia0LLR  = '0;
    bus.ia1LLR  = '0;
    bus.irempty = 1'b0;
    bus.iraddr  = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    iclkena  = 1'b1;
    ireset_n = 1'b0;
    cyc();
    cyc();
    ireset_n = 1'b1;
    cyc();
  endtask

  task automatic drive_word(input int a, input int k, input bit full, input int tag);
    bus.iwrite = 1'b1;
    bus.iwaddr = A'(a);
    bus.iwfull = full;
    bus.itag   = T'(tag);
    bus.isLLR  = fld(k, 0);
    for (int j = 0; j < 3; j++) begin
      bus.ia0LLR[j] = fld(k, 1 + j);
      bus.ia1LLR[j] = fld(k, 4 + j);
    end
    cyc();
    bus.iwrite = 1'b0;
    bus.iwfull = 1'b0;
  endtask

  task automatic close_only(input int tag);
    bus.iwfull = 1'b1;
    bus.itag   = T'(tag);
    bus.iwaddr = A'(200);
    cyc();
    bus.iwfull = 1'b0;
  endtask

  task automatic read_word(input int a, output logic [7*W-1:0] w);
    bus.iraddr = A'(a);
    cyc();
    cyc();
    w = {bus.osLLR, bus.oa0LLR, bus.oa1LLR};
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.ofulla, bus.oemptya, bus.ordy, bus.oerr} !== 4'b0100) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0100", {bus.ofulla, bus.oemptya, bus.ordy, bus.oerr});
    end
    checks++;
    if ({bus.olen, bus.otag, bus.osLLR, bus.oa0LLR, bus.oa1LLR} !== '0) begin
      errors++;
      $display("FAIL reset_data: olen=%0d otag=%0d s=%h", bus.olen, bus.otag, bus.osLLR);
    end
  endtask

  task automatic test_single_block();
    logic [7*W-1:0] w;
    do_reset();
    for (int a = 0; a < 10; a++) drive_word(a, a, a == 9, 5);
    checks++;
    if ({bus.ordy, bus.oemptya, bus.ofulla} !== 3'b100) begin
      errors++;
      $display("FAIL single_flags: got %b want 100", {bus.ordy, bus.oemptya, bus.ofulla});
    end
    cyc();
    checks++;
    if (bus.olen !== A'(9) || bus.otag !== T'(5)) begin
      errors++;
      $display("FAIL single_len_tag: olen=%0d otag=%0d want 9/5", bus.olen, bus.otag);
    end
    for (int a = 0; a < 10; a++) begin
      read_word(a, w);
      checks++;
      if (w !== exp_word(a)) begin
        errors++;
        $display("FAIL single_read[%0d]: got %h want %h", a, w, exp_word(a));
      end
    end
  endtask

  task automatic test_late_close();
    do_reset();
    for (int a = 0; a < 4; a++) drive_word(a, 20 + a, 1'b0, 0);
    cyc();
    close_only(3);
    checks++;
    if (bus.ordy !== 1'b1) begin
      errors++;
      $display("FAIL late_ordy: got %b want 1", bus.ordy);
    end
    cyc();
    checks++;
    if (bus.olen !== A'(3) || bus.otag !== T'(3)) begin
      errors++;
      $display("FAIL late_len: olen=%0d otag=%0d want 3/3", bus.olen, bus.otag);
    end
  endtask

  // Leaves both banks full (lengths 4 and 7) for test_release_order.
  task automatic test_fill_overflow();
    logic [7*W-1:0] w;
    do_reset();
    for (int a = 0; a < 5; a++) drive_word(a, a, a == 4, 1);
    for (int a = 0; a < 8; a++) drive_word(a, 100 + a, a == 7, 2);
    checks++;
    if ({bus.ofulla, bus.oemptya, bus.ordy, bus.oerr} !== 4'b1010) begin
      errors++;
      $display("FAIL fill_flags: got %b want 1010", {bus.ofulla, bus.oemptya, bus.ordy, bus.oerr});
    end
    drive_word(0, 50, 1'b0, 0);
    close_only(9);
    checks++;
    if (bus.oerr !== 1'b1 || bus.ofulla !== 1'b1) begin
      errors++;
      $display("FAIL overflow_err: oerr=%b ofulla=%b want 1/1", bus.oerr, bus.ofulla);
    end
    checks++;
    if (bus.olen !== A'(4) || bus.otag !== T'(1)) begin
      errors++;
      $display("FAIL overflow_len: olen=%0d otag=%0d want 4/1", bus.olen, bus.otag);
    end
    for (int a = 0; a < 5; a++) begin
      read_word(a, w);
      checks++;
      if (w !== exp_word(a)) begin
        errors++;
        $display("FAIL bank0_intact[%0d]: got %h want %h", a, w, exp_word(a));
      end
    end
  endtask

  task automatic test_release_order();
    logic [7*W-1:0] w;
    bus.irempty = 1'b1;
    cyc();
    bus.irempty = 1'b0;
    checks++;
    if ({bus.ofulla, bus.oemptya, bus.ordy} !== 3'b001) begin
      errors++;
      $display("FAIL release1_flags: got %b want 001", {bus.ofulla, bus.oemptya, bus.ordy});
    end
    cyc();
    checks++;
    if (bus.olen !== A'(7) || bus.otag !== T'(2)) begin
      errors++;
      $display("FAIL release1_len: olen=%0d otag=%0d want 7/2", bus.olen, bus.otag);
    end
    read_word(7, w);
    checks++;
    if (w !== exp_word(107)) begin
      errors++;
      $display("FAIL bank1_read: got %h want %h", w, exp_word(107));
    end
    bus.irempty = 1'b1;
    cyc();
    bus.irempty = 1'b0;
    checks++;
    if ({bus.ofulla, bus.oemptya, bus.ordy} !== 3'b010) begin
      errors++;
      $display("FAIL release2_flags: got %b want 010", {bus.ofulla, bus.oemptya, bus.ordy});
    end
  endtask

  task automatic test_back_to_back();
    logic [7*W-1:0] w;
    do_reset();
    for (int a = 0; a < 3; a++) drive_word(a, 10 + a, a == 2, 3);
    for (int a = 0; a < 5; a++) drive_word(a, 200 + a, 1'b0, 0);
    bus.irempty = 1'b1;
    drive_word(5, 205, 1'b1, 6);
    bus.irempty = 1'b0;
    checks++;
    if ({bus.ofulla, bus.oemptya, bus.ordy, bus.oerr} !== 4'b0010) begin
      errors++;
      $display("FAIL simul_used1_flags: got %b want 0010", {bus.ofulla, bus.oemptya, bus.ordy, bus.oerr});
    end
    cyc();
    checks++;
    if (bus.olen !== A'(5) || bus.otag !== T'(6)) begin
      errors++;
      $display("FAIL simul_used1_len: olen=%0d otag=%0d want 5/6", bus.olen, bus.otag);
    end
    read_word(5, w);
    checks++;
    if (w !== exp_word(205)) begin
      errors++;
      $display("FAIL simul_read: got %h want %h", w, exp_word(205));
    end
    for (int a = 0; a < 2; a++) drive_word(a, 300 + a, a == 1, 7);
    bus.irempty = 1'b1;
    close_only(8);
    bus.irempty = 1'b0;
    checks++;
    if ({bus.ofulla, bus.ordy, bus.oerr} !== 3'b110) begin
      errors++;
      $display("FAIL simul_used2_flags: got %b want 110", {bus.ofulla, bus.ordy, bus.oerr});
    end
    cyc();
    checks++;
    if (bus.olen !== A'(1) || bus.otag !== T'(7)) begin
      errors++;
      $display("FAIL simul_used2_len: olen=%0d otag=%0d want 1/7", bus.olen, bus.otag);
    end
  endtask

  task automatic test_underflow_reset();
    logic [7*W-1:0] w;
    do_reset();
    iclkena     = 1'b0;
    bus.irempty = 1'b1;
    cyc();
    bus.irempty = 1'b0;
    iclkena     = 1'b1;
    checks++;
    if (bus.oerr !== 1'b0) begin
      errors++;
      $display("FAIL clkena_hold: oerr=%b want 0", bus.oerr);
    end
    bus.irempty = 1'b1;
    cyc();
    bus.irempty = 1'b0;
    checks++;
    if ({bus.oerr, bus.ofulla, bus.oemptya, bus.ordy} !== 4'b1010) begin
      errors++;
      $display("FAIL underflow: got %b want 1010", {bus.oerr, bus.ofulla, bus.oemptya, bus.ordy});
    end
    do_reset();
    for (int a = 0; a < 4; a++) drive_word(a, 400 + a, a == 3, 4);
    read_word(2, w);
    checks++;
    if (w !== exp_word(402) || bus.olen !== A'(3)) begin
      errors++;
      $display("FAIL pre_reset_read: got %h len %0d want %h len 3", w, bus.olen, exp_word(402));
    end
    drive_word(0, 500, 1'b0, 0);
    #2;
    ireset_n = 1'b0;
    #1;
    checks++;
    if ({bus.ofulla, bus.oemptya, bus.ordy, bus.oerr} !== 4'b0100 ||
        {bus.olen, bus.otag, bus.osLLR, bus.oa0LLR, bus.oa1LLR} !== '0) begin
      errors++;
      $display("FAIL async_reset: flags=%b olen=%0d otag=%0d s=%h",
               {bus.ofulla, bus.oemptya, bus.ordy, bus.oerr}, bus.olen, bus.otag, bus.osLLR);
    end
    cyc();
    ireset_n = 1'b1;
    cyc();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_block();
    test_late_close();
    test_fill_overflow();
    test_release_order();
    test_back_to_back();
    test_underflow_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
